// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Tracks register-use info of the instructions in E/M/W, drives the EX operand
// forwarding selects, the load-use stall / redirect flush controls, and keeps
// saturating counters of stall cycles and flush events.
module hazard_forward_unit #(
   parameter int unsigned RA_W  = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RA_W-1:0]  Rs1D,
   input  logic [RA_W-1:0]  Rs2D,
   input  logic [RA_W-1:0]  RdD,
   input  logic             RegWriteD,
   input  logic             LoadD,
   input  logic             PCSrcE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Register-use info carried by the instruction in Execute
   typedef struct packed {
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      logic            regwrite;
      logic            load;
   } ex_info_t;

   // Only the destination matters once an instruction leaves Execute
   typedef struct packed {
      logic [RA_W-1:0] rd;
      logic            regwrite;
   } wb_info_t;

   ex_info_t ex_q;
   ex_info_t ex_d;
   wb_info_t mem_q;
   wb_info_t wb_q;

   logic lw_stall;
   logic redirect;

   // Pick the youngest in-flight producer of rs; x0 is hard-wired zero, never forwarded
   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                          input wb_info_t        mem,
                                          input wb_info_t        wb);
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem.regwrite && (mem.rd != '0) && (mem.rd == rs)) begin
         sel = FWD_MEM;
      end else if (wb.regwrite && (wb.rd != '0) && (wb.rd == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   // Load-use detection; a redirect in E wins so the PC can take the target
   always_comb begin
      lw_stall = 1'b0;
      redirect = PCSrcE & ~reset;
      if (ex_q.load && ex_q.regwrite && (ex_q.rd != '0) &&
          ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D)) && !PCSrcE) begin
         lw_stall = 1'b1;
      end
   end

   // Pipeline-register controls
   always_comb begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = redirect;
      FlushE = lw_stall | redirect;
   end

   // Operand forwarding selects for the instruction currently in Execute
   always_comb begin
      ForwardAE = fwd_sel(ex_q.rs1, mem_q, wb_q);
      ForwardBE = fwd_sel(ex_q.rs2, mem_q, wb_q);
   end

   // Next E shadow entry: the Decode instruction, or a bubble when E is flushed
   always_comb begin
      ex_d.rs1      = Rs1D;
      ex_d.rs2      = Rs2D;
      ex_d.rd       = RdD;
      ex_d.regwrite = RegWriteD;
      ex_d.load     = LoadD;
      if (FlushE) begin
         ex_d = '0;
      end
   end

   // Shadow pipeline E -> M -> W; M and W always advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q           <= ex_d;
         mem_q.rd       <= ex_q.rd;
         mem_q.regwrite <= ex_q.regwrite;
         wb_q           <= mem_q;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (lw_stall && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
         end
         if (PCSrcE && (FlushCount != '1)) begin
            FlushCount <= FlushCount + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scenario bench for hazard_forward_unit: drives Decode-stage instruction
// streams, queues the expected controls per cycle, and compares them.
module tb_hazard_forward_unit;

   localparam int unsigned RA_W  = 5;
   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [RA_W-1:0]  Rs1D, Rs2D, RdD;
   logic             RegWriteD, LoadD, PCSrcE;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, FlushD, FlushE;
   logic [CNT_W-1:0] StallCount, FlushCount;

   hazard_forward_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       rw, ld, pc;
      logic [1:0] fa, fb;
      logic       st, fd, fe;
   } step_t;

   typedef struct {
      string       name;
      logic [15:0] v;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] exp_sc, exp_fc;
   int         total, bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   function automatic step_t mk(input int rs1, input int rs2, input int rd,
                                input bit rw, input bit ld, input bit pc,
                                input int fa, input int fb,
                                input bit st, input bit fd, input bit fe);
      step_t s;
      s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
      s.rw = rw; s.ld = ld; s.pc = pc;
      s.fa = 2'(fa); s.fb = 2'(fb);
      s.st = st; s.fd = fd; s.fe = fe;
      return s;
   endfunction

   function automatic step_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic logic [3:0] sat(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'h1;
   endfunction

   function automatic logic [15:0] observed();
      return {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount};
   endfunction

   // Drive one Decode instruction and queue what the unit must show this cycle
   task automatic apply(input step_t s, input string nm);
      exp_t e;
      @(negedge clk);
      Rs1D = s.rs1; Rs2D = s.rs2; RdD = s.rd;
      RegWriteD = s.rw; LoadD = s.ld; PCSrcE = s.pc;
      e.name = nm;
      e.v = {s.fa, s.fb, s.st, s.st, s.fd, s.fe, exp_sc, exp_fc};
      exp_q.push_back(e);
   endtask

   // Counter model advances on the edge following the sampled cycle
   task automatic advance(input step_t s);
      if (s.st) exp_sc = sat(exp_sc);
      if (s.pc) exp_fc = sat(exp_fc);
   endtask

   task automatic test_reset();
      exp_t e;
      logic [15:0] got;
      @(negedge clk);
      e.name = "reset_hold"; e.v = 16'h0; exp_q.push_back(e);
      #1;
      e = exp_q.pop_front(); got = observed(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.name, got, e.v); end
      @(negedge clk);
      reset = 1'b0;
      e.name = "reset_release"; e.v = 16'h0; exp_q.push_back(e);
      #1;
      e = exp_q.pop_front(); got = observed(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.name, got, e.v); end
   endtask

   task automatic test_fwd_mem();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      s.push_back(mk(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(5, 3, 6, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "fwd_mem");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_fwd_wb();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      s.push_back(mk(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(nop());
      s.push_back(mk(4, 5, 7, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "fwd_wb");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_fwd_priority();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      s.push_back(mk(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(3, 4, 5, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(5, 5, 8, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0));
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "fwd_priority");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_x0();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      s.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(nop());
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "x0_never");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_load_use();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      // lw x6 ; add x7,x6,x2 (rs1 hazard)
      s.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(6, 2, 7, 1, 0, 0, 0, 0, 1, 0, 1));
      s.push_back(mk(6, 2, 7, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      s.push_back(nop());
      s.push_back(nop());
      // lw x6 ; add x7,x2,x6 (rs2 hazard)
      s.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(2, 6, 7, 1, 0, 0, 0, 0, 1, 0, 1));
      s.push_back(mk(2, 6, 7, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      // lw x0 ; add x7,x0,x0 -> no stall
      s.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "load_use");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_redirect();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      s.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(6, 2, 7, 1, 0, 1, 0, 0, 0, 1, 1));
      s.push_back(nop());
      s.push_back(nop());
      s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "redirect");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      // lw x6 ; lw x7,0(x6) ; add x8,x7,x6
      s.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(6, 0, 7, 1, 1, 0, 0, 0, 1, 0, 1));
      s.push_back(mk(6, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(7, 6, 8, 1, 0, 0, 1, 0, 1, 0, 1));
      s.push_back(mk(7, 6, 8, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "back_to_back");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_saturation();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      for (int k = 0; k < 16; k++) begin
         s.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
         s.push_back(mk(6, 2, 7, 1, 0, 0, 0, 0, 1, 0, 1));
         s.push_back(mk(6, 2, 7, 1, 0, 0, 0, 0, 0, 0, 0));
         s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      for (int k = 0; k < 16; k++) begin
         s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
      end
      s.push_back(nop());
      s.push_back(nop());
      foreach (s[i]) begin
         apply(s[i], "saturation");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   task automatic test_reset_mid_stall();
      step_t s[$];
      exp_t e;
      logic [15:0] got;
      s.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(6, 2, 7, 1, 0, 0, 0, 0, 1, 0, 1));
      foreach (s[i]) begin
         apply(s[i], "pre_reset");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
      end
      // Assert reset while the stall is showing, before the clock edge
      #1;
      reset = 1'b1;
      exp_sc = 4'h0; exp_fc = 4'h0;
      e.name = "reset_async"; e.v = 16'h0; exp_q.push_back(e);
      #1;
      e = exp_q.pop_front(); got = observed(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.name, got, e.v); end
      @(negedge clk);
      PCSrcE = 1'b1;
      e.name = "reset_held_pcsrc"; e.v = 16'h0; exp_q.push_back(e);
      #1;
      e = exp_q.pop_front(); got = observed(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.name, got, e.v); end
      @(negedge clk);
      reset = 1'b0;
      Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; LoadD = 1'b0; PCSrcE = 1'b0;
      e.name = "reset_after"; e.v = 16'h0; exp_q.push_back(e);
      #1;
      e = exp_q.pop_front(); got = observed(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.name, got, e.v); end
      // Counters restart from zero
      s.delete();
      s.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(6, 2, 7, 1, 0, 0, 0, 0, 1, 0, 1));
      s.push_back(mk(6, 2, 7, 1, 0, 0, 0, 0, 0, 0, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i], "post_reset");
         #1;
         e = exp_q.pop_front(); got = observed(); total++;
         if (got !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h need=%h", e.name, i, got, e.v); end
         advance(s[i]);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      exp_sc = 4'h0; exp_fc = 4'h0;
      reset = 1'b1;
      Rs1D = '0; Rs2D = '0; RdD = '0;
      RegWriteD = 1'b0; LoadD = 1'b0; PCSrcE = 1'b0;
      test_reset();
      test_fwd_mem();
      test_fwd_wb();
      test_fwd_priority();
      test_x0();
      test_load_use();
      test_redirect();
      test_back_to_back();
      test_saturation();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
